// File: rtl/fwrisc_exec_issue_arb_if.sv
// Issue-arbiter bundle: two requester handshakes plus the exec-side
// instruction outputs and completion input.
interface fwrisc_exec_issue_arb_if;
   logic         req0_valid;
   logic [113:0] req0_op;
   logic         req0_ack;
   logic         req1_valid;
   logic [113:0] req1_op;
   logic         req1_ack;
   logic         decode_valid;
   logic         instr_c;
   logic [4:0]   op_type;
   logic [31:0]  op_a;
   logic [31:0]  op_b;
   logic [5:0]   op;
   logic [31:0]  op_c;
   logic [5:0]   rd;
   logic         instr_complete;
   logic         owner;
   logic         timeout_err;

   modport slave (
      input  req0_valid, req0_op, req1_valid, req1_op, instr_complete,
      output req0_ack, req1_ack, decode_valid, instr_c, op_type, op_a, op_b,
             op, op_c, rd, owner, timeout_err
   );

   modport master (
      output req0_valid, req0_op, req1_valid, req1_op, instr_complete,
      input  req0_ack, req1_ack, decode_valid, instr_c, op_type, op_a, op_b,
             op, op_c, rd, owner, timeout_err
   );
endinterface

// File: rtl/fwrisc_exec_issue_arb.sv
// Two-requester issue controller for the fwrisc exec stage: arbitrates,
// latches one op bundle at a time and watches for an exec stage that hangs.
module fwrisc_exec_issue_arb #(
   parameter bit          RR_EN          = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                    clock,
   input logic                    reset_n,
   fwrisc_exec_issue_arb_if.slave bus
);
   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FAULT} state_e;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_owner_q, last_owner_d;
   logic          valid_q, valid_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [113:0]  op_q, op_d;
   logic          winner;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      valid_d      = valid_q;
      timeout_d    = timeout_q;
      cnt_d        = cnt_q;
      op_d         = op_q;

      // last_owner resets to 1 so req0 takes the first round-robin tie
      if (RR_EN && bus.req0_valid && bus.req1_valid) winner = ~last_owner_q;
      else                                           winner = bus.req1_valid;

      case (state_q)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               state_d      = S_ISSUE;
               valid_d      = 1'b1;
               owner_d      = winner;
               last_owner_d = winner;
               op_d         = winner ? bus.req1_op : bus.req0_op;
               cnt_d        = '0;
            end
         end
         S_ISSUE: begin
            // a completion on the final watchdog cycle still counts as normal
            if (bus.instr_complete) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               state_d   = S_FAULT;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FAULT: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
         op_q         <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
      end
   end

   // decode_valid drops in the completion cycle itself
   assign bus.decode_valid = valid_q & ~bus.instr_complete;
   assign bus.req0_ack     = (state_q == S_ISSUE) & bus.instr_complete & ~owner_q;
   assign bus.req1_ack     = (state_q == S_ISSUE) & bus.instr_complete &  owner_q;
   assign bus.owner        = owner_q;
   assign bus.timeout_err  = timeout_q;
   assign {bus.instr_c, bus.op_type, bus.op_a, bus.op_b, bus.op, bus.op_c, bus.rd} = op_q;
endmodule

// File: tb/tb_fwrisc_exec_issue_arb.sv
// Bench for fwrisc_exec_issue_arb: round-robin and fixed-priority instances share
// stimulus; a transaction-level model predicts both every cycle.
module tb_fwrisc_exec_issue_arb;
   localparam int TO = 8;
   localparam logic [5:0] OP_EQ = 6'd10;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         rstn, v0, v1, cmp;
   logic [113:0] op0, op1;

   fwrisc_exec_issue_arb_if ifa();
   fwrisc_exec_issue_arb_if ifb();

   assign ifa.req0_valid = v0;  assign ifb.req0_valid = v0;
   assign ifa.req1_valid = v1;  assign ifb.req1_valid = v1;
   assign ifa.req0_op    = op0; assign ifb.req0_op    = op0;
   assign ifa.req1_op    = op1; assign ifb.req1_op    = op1;
   assign ifa.instr_complete = cmp;
   assign ifb.instr_complete = cmp;

   fwrisc_exec_issue_arb #(.RR_EN(1'b1), .TIMEOUT_CYCLES(TO)) dut_a (
      .clock(clock), .reset_n(rstn), .bus(ifa));
   fwrisc_exec_issue_arb #(.RR_EN(1'b0), .TIMEOUT_CYCLES(TO)) dut_b (
      .clock(clock), .reset_n(rstn), .bus(ifb));

   int n_tests = 0;
   int n_fail  = 0;

   // model: index 0 = round-robin instance, 1 = fixed-priority instance
   bit           m_busy[2], m_fault[2], m_owner[2], m_last[2];
   int           m_age[2];
   logic [113:0] m_bundle[2];

   logic         s_dv[2], s_ack0[2], s_ack1[2], s_owner[2], s_terr[2];
   logic [113:0] s_ops[2];

   typedef struct {
      logic v0, v1, c;
      logic dv, ack0, ack1, owner;
   } vec_t;
   vec_t tbl[6];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [113:0] act, input logic [113:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_fault[d] = 0; m_owner[d] = 0; m_last[d] = 1;
         m_age[d] = 0; m_bundle[d] = '0;
      end
   endtask

   // one clock: drive, check both DUTs against the model, advance the model
   task automatic cyc(input logic r, input logic a0, input logic a1, input logic c);
      @(negedge clock);
      rstn = r; v0 = a0; v1 = a1; cmp = c;
      #1;
      s_dv[0] = ifa.decode_valid; s_ack0[0] = ifa.req0_ack; s_ack1[0] = ifa.req1_ack;
      s_owner[0] = ifa.owner; s_terr[0] = ifa.timeout_err;
      s_ops[0] = {ifa.instr_c, ifa.op_type, ifa.op_a, ifa.op_b, ifa.op, ifa.op_c, ifa.rd};
      s_dv[1] = ifb.decode_valid; s_ack0[1] = ifb.req0_ack; s_ack1[1] = ifb.req1_ack;
      s_owner[1] = ifb.owner; s_terr[1] = ifb.timeout_err;
      s_ops[1] = {ifb.instr_c, ifb.op_type, ifb.op_a, ifb.op_b, ifb.op, ifb.op_c, ifb.rd};
      for (int d = 0; d < 2; d++) begin
         string tag;
         logic  w;
         tag = (d == 0) ? "rr" : "fp";
         chk1({tag, ".decode_valid"}, s_dv[d], m_busy[d] && !c);
         chk1({tag, ".req0_ack"}, s_ack0[d], m_busy[d] && c && !m_owner[d]);
         chk1({tag, ".req1_ack"}, s_ack1[d], m_busy[d] && c && m_owner[d]);
         chk1({tag, ".owner"}, s_owner[d], m_owner[d]);
         chk1({tag, ".timeout_err"}, s_terr[d], m_fault[d]);
         chkv({tag, ".ops"}, s_ops[d], m_bundle[d]);
         if (!r) begin
            m_busy[d] = 0; m_fault[d] = 0; m_owner[d] = 0; m_last[d] = 1;
            m_age[d] = 0; m_bundle[d] = '0;
         end else if (m_fault[d]) begin
         end else if (!m_busy[d]) begin
            if (a0 || a1) begin
               w = (d == 0 && a0 && a1) ? !m_last[d] : a1;
               m_busy[d] = 1; m_owner[d] = w; m_last[d] = w; m_age[d] = 0;
               m_bundle[d] = w ? op1 : op0;
            end
         end else if (c) begin
            m_busy[d] = 0;
         end else if (m_age[d] == TO - 1) begin
            m_busy[d] = 0; m_fault[d] = 1;
         end else begin
            m_age[d]++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [113:0] b1;
      int exp_own[4];
      exp_own = '{0, 1, 0, 1};

      rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; cmp = 1'b0; op0 = '0; op1 = '0;
      repeat (2) @(posedge clock);
      #1;
      model_reset();

      // 1: single req0 instruction, table driven
      b1  = {1'b0, 5'd2, 32'd5, 32'd5, OP_EQ, 32'd8, 6'd3};
      op0 = b1;
      op1 = {1'b1, 5'd7, 32'hdead_beef, 32'h1234_5678, 6'd1, 32'hcafe_f00d, 6'd9};
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, tbl[i].v0, tbl[i].v1, tbl[i].c);
         if (i == 0) chkv("reset.ops", s_ops[0], 114'd0);
         chk1($sformatf("t1[%0d].dv", i),    s_dv[0],    tbl[i].dv);
         chk1($sformatf("t1[%0d].ack0", i),  s_ack0[0],  tbl[i].ack0);
         chk1($sformatf("t1[%0d].ack1", i),  s_ack1[0],  tbl[i].ack1);
         chk1($sformatf("t1[%0d].owner", i), s_owner[0], tbl[i].owner);
         chk1($sformatf("t1[%0d].terr", i),  s_terr[0],  1'b0);
         if (i >= 1 && i <= 3) chkv($sformatf("t1[%0d].ops", i), s_ops[0], b1);
      end

      // 2: round-robin alternation with both requesters always valid
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0);
         cyc(1'b1, 1'b1, 1'b1, 1'b1);
         chk1($sformatf("rr.owner[%0d]", k), s_owner[0], exp_own[k][0]);
         chk1($sformatf("rr.ack0[%0d]", k), s_ack0[0], !exp_own[k][0]);
         chk1($sformatf("rr.ack1[%0d]", k), s_ack1[0], exp_own[k][0]);
      end

      // 3: fixed priority keeps granting req1 until it drops
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0);
         cyc(1'b1, 1'b1, 1'b1, 1'b1);
         chk1($sformatf("fp.owner[%0d]", k), s_owner[1], 1'b1);
         chk1($sformatf("fp.ack1[%0d]", k), s_ack1[1], 1'b1);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk1("fp.owner_req0", s_owner[1], 1'b0);
      chk1("fp.ack0_req0", s_ack0[1], 1'b1);

      // 4: watchdog expiry is terminal until reset
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < TO; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         chk1($sformatf("wd.dv[%0d]", i), s_dv[0], 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b1);
         chk1("wd.terr", s_terr[0], 1'b1);
         chk1("wd.dv_off", s_dv[0], 1'b0);
         chk1("wd.no_ack0", s_ack0[0], 1'b0);
         chk1("wd.no_ack1", s_ack1[0], 1'b0);
      end
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk1("wd.terr_cleared", s_terr[0], 1'b0);

      // 5: reset in the middle of an issue
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk1("mid.dv_before", s_dv[0], 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk1("mid.dv_after", s_dv[0], 1'b0);
      chkv("mid.ops_after", s_ops[0], 114'd0);
      chk1("mid.no_ack", s_ack0[0], 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk1("mid.regrant_dv", s_dv[0], 1'b1);
      chk1("mid.regrant_owner", s_owner[0], 1'b0);

      // 6: idle completion ignored; completion on the last watchdog cycle wins
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk1("edge.idle_ack", s_ack0[0], 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk1("edge.grant_ack", s_ack0[0], 1'b0);
      for (int i = 0; i < TO - 1; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk1("edge.last_ack", s_ack0[0], 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk1("edge.no_terr", s_terr[0], 1'b0);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         op0 = {$urandom, $urandom, $urandom, $urandom};
         op1 = {$urandom, $urandom, $urandom, $urandom};
         cyc($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
